// File: rtl/instr_fetch_reg.sv
// Multicycle instruction fetch and instruction register.
// Issues one memory read per request and decodes the held word.
module instr_fetch_reg #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_rd,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  output logic [WIDTH-1:0]   ir,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [WIDTH/2-1:0] imm,
  output logic [25:0]        jaddr,
  output logic               ir_valid,
  output logic               busy,
  output logic               fetch_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] LAST   = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      mem_addr  <= '0;
      wait_cnt  <= '0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fetch_req) begin
            mem_addr  <= pc;
            mem_rd    <= 1'b1;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // capture beats the timeout on the same edge
          if (mem_ready) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (wait_cnt == LAST) begin
            fetch_err <= 1'b1;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[WIDTH/2-1:0];
  assign jaddr  = ir[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: directed steps plus random
// fetches checked against a transaction-level model.
module tb_instr_fetch_reg;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem_addr, ir;
  logic        mem_rd, ir_valid, busy, fetch_err;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int starts = 0;
  logic prev_rd = 1'b0;
  logic [31:0] exp_ir = '0;
  logic        exp_err = 1'b0;

  instr_fetch_reg #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .pc(pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .jaddr(jaddr),
    .ir_valid(ir_valid), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_rd && !prev_rd) starts++;
    prev_rd = mem_rd;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic fields(input logic [31:0] d);
    chk("opcode", 32'(opcode), d >> 26);
    chk("rs", 32'(rs), (d >> 21) & 32'h1f);
    chk("rt", 32'(rt), (d >> 16) & 32'h1f);
    chk("rd", 32'(rd), (d >> 11) & 32'h1f);
    chk("shamt", 32'(shamt), (d >> 6) & 32'h1f);
    chk("funct", 32'(funct), d & 32'h3f);
    chk("imm", 32'(imm), d & 32'hffff);
    chk("jaddr", 32'(jaddr), d & 32'h3ffffff);
  endtask

  // Fetch whose data arrives on WAIT edge lat; lat>TO never arrives.
  task automatic fetch(input logic [31:0] p,
                       input logic [31:0] d,
                       input int lat);
    pc = p;
    fetch_req = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    n_acc++;
    exp_err = 1'b0;
    fetch_req = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_rd", mem_rd, 1);
    chk("acc_addr", mem_addr, p);
    chk("acc_err", fetch_err, 0);
    chk("acc_irv", ir_valid, 0);
    for (int k = 1; k <= TO; k++) begin
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? d : $urandom;
      pc = $urandom;
      fetch_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == lat) begin
        exp_ir = d;
        chk("cap_ir", ir, d);
        chk("cap_irv", ir_valid, 1);
        chk("cap_busy", busy, 0);
        chk("cap_rd", mem_rd, 0);
        chk("cap_err", fetch_err, 0);
        break;
      end else if (k == TO) begin
        exp_err = 1'b1;
        chk("to_err", fetch_err, 1);
        chk("to_busy", busy, 0);
        chk("to_rd", mem_rd, 0);
        chk("to_ir", ir, exp_ir);
        chk("to_irv", ir_valid, 0);
      end else begin
        chk("w_busy", busy, 1);
        chk("w_rd", mem_rd, 1);
        chk("w_addr", mem_addr, p);
        chk("w_irv", ir_valid, 0);
        chk("w_ir", ir, exp_ir);
      end
    end
    fetch_req = 1'b0;
    mem_ready = 1'b0;
    pc = $urandom;
  endtask

  task automatic idle(input logic rdy);
    fetch_req = 1'b0;
    mem_ready = rdy;
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ir", ir, exp_ir);
    chk("idle_irv", ir_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rd", mem_rd, 0);
    chk("idle_err", fetch_err, exp_err);
  endtask

  initial begin
    logic [31:0] a, d;
    int lat;

    repeat (2) @(negedge clk);
    chk("rst_ir", ir, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b0;

    fetch(32'h00400000, 32'h2008FFFC, 1);
    chk("z_opcode", 32'(opcode), 32'h08);
    chk("z_rs", 32'(rs), 0);
    chk("z_rt", 32'(rt), 8);
    chk("z_imm", 32'(imm), 32'hFFFC);
    idle(1'b0);

    fetch(32'h00400004, 32'h012A4020, 5);
    chk("w_rd8", 32'(rd), 8);
    chk("w_funct", 32'(funct), 32'h20);
    chk("w_shamt", 32'(shamt), 0);
    idle(1'b1);

    fetch(32'h00400008, 32'hDEADBEEF, TO + 3);
    idle(1'b0);
    idle(1'b1);

    fetch(32'h0040000C, 32'h8D090004, 2);
    fields(32'h8D090004);

    fetch(32'h00400010, 32'h3C011001, 1);
    fetch(32'h00400014, 32'h08100000, 3);
    fields(32'h08100000);
    idle(1'b0);

    fetch(32'h00400018, 32'hAC0A0008, TO);
    fields(32'hAC0A0008);
    idle(1'b0);

    pc = 32'h0040001C;
    fetch_req = 1'b1;
    @(negedge clk);
    n_acc++;
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ir = '0;
    exp_err = 1'b0;
    chk("mr_ir", ir, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_rd", mem_rd, 0);
    chk("mr_busy", busy, 0);
    chk("mr_irv", ir_valid, 0);
    chk("mr_err", fetch_err, 0);
    idle(1'b1);

    reset = 1'b1;
    fetch_req = 1'b1;
    pc = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    fetch_req = 1'b0;
    chk("rf_busy", busy, 0);
    chk("rf_rd", mem_rd, 0);
    chk("rf_addr", mem_addr, 0);

    repeat (40) begin
      repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
      a = $urandom;
      d = $urandom;
      lat = $urandom_range(1, TO + 2);
      fetch(a, d, lat);
      if (lat <= TO) fields(d);
    end
    idle(1'b0);
    chk("rd_starts", 32'(starts), 32'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
# instr_fetch_reg

Multicycle instruction fetch unit and instruction register. On a fetch request from the control unit, it issues a read to the unified memory and waits a variable number of cycles for the data. It captures the returned word into the instruction register and decodes the held word into fixed MIPS fields. Its `imm` output feeds the sign-extend stage directly; the other fields go to the register file, the control unit and the jump-address logic.

## Interface
- `WIDTH`, 32: datapath and instruction width. Must be 32 for the MIPS field split.
- `TIMEOUT`, 15: number of WAIT-state edges without `mem_ready` before the fetch aborts. Valid range is 1..255.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: control requests a fetch. Sampled only in IDLE.
- `pc` in WIDTH: fetch address. Sampled together with an accepted `fetch_req`.
- `mem_addr` out WIDTH: registered memory address.
- `mem_rd` out 1: registered memory read strobe.
- `mem_rdata` in WIDTH: memory read data. Valid when `mem_ready`=1.
- `mem_ready` in 1: memory data valid this cycle.
- `ir` out WIDTH: instruction register.
- `opcode` out 6: `ir[31:26]`.
- `rs` out 5: `ir[25:21]`.
- `rt` out 5: `ir[20:16]`.
- `rd` out 5: `ir[15:11]`.
- `shamt` out 5: `ir[10:6]`.
- `funct` out 6: `ir[5:0]`.
- `imm` out WIDTH/2: `ir[15:0]`. Goes to sign-extend.
- `jaddr` out 26: `ir[25:0]`.
- `ir_valid` out 1: one-cycle pulse. Means `ir` was just loaded.
- `busy` out 1: a fetch is in progress.
- `fetch_err` out 1: sticky timeout flag.

## Operation
- States:
  - IDLE: `busy`=0, `mem_rd`=0.
  - WAIT: `busy`=1, `mem_rd`=1.
  - A 2-state FSM; no other states are legal.
- IDLE, with `fetch_req`=1 at an edge:
  - Set `mem_addr` <= `pc`, `mem_rd` <= 1, `busy` <= 1, `wait_cnt` <= 0, `fetch_err` <= 0.
  - Go to WAIT.
- IDLE, with `fetch_req`=0: all registers hold. `mem_ready` is ignored.
- WAIT, with `mem_ready`=1 at an edge:
  - Set `ir` <= `mem_rdata`, `ir_valid` <= 1, `mem_rd` <= 0, `busy` <= 0.
  - Go to IDLE.
- WAIT, with `mem_ready`=0:
  - If `wait_cnt` = TIMEOUT-1: set `fetch_err` <= 1, `mem_rd` <= 0, `busy` <= 0, and go to IDLE. `ir` is not modified.
  - Otherwise: `wait_cnt` <= `wait_cnt`+1.
- `fetch_req` during WAIT is ignored. It is not queued.
- `mem_addr` is stable for the whole WAIT interval. `pc` changes during WAIT have no effect.
- `ir_valid` is high for exactly one cycle per successful fetch. It is forced to 0 on every edge where no capture occurs.
- Field outputs are combinational slices of `ir`. They change only when `ir` loads, so `imm` is stable for the sign-extend stage between fetches.
- `wait_cnt` is 8 bits. It cannot wrap, given the TIMEOUT range.
- `fetch_err` stays at 1 until the next accepted `fetch_req` or `reset`.

## Timing
- Reset values:
  - State IDLE.
  - `ir`, `mem_addr`, `wait_cnt` = 0.
  - `mem_rd`, `busy`, `ir_valid`, `fetch_err` = 0.
- Reset has priority over all other inputs.
- Reset mid-WAIT:
  - Next cycle is IDLE with `mem_rd`=0.
  - Any late `mem_ready` is ignored.
  - `ir` = 0.
- Latency, best case:
  - `fetch_req` sampled at edge E0.
  - `mem_rd`=1 during cycle E0..E1.
  - `mem_ready`=1 sampled at E1.
  - `ir` and `ir_valid`=1 valid after E1.
  - Total: 2 edges from request to valid `ir`.
- General latency: a memory that takes N≥1 cycles in WAIT gives `ir_valid` after edge E0+N.
- Timeout: with `mem_ready` held low, `fetch_err` rises after edge E0+TIMEOUT. `busy` falls on the same edge.
- Back-to-back: `fetch_req`=1 in the cycle where `ir_valid`=1 (state is IDLE) is accepted. `mem_rd` is then high again in the following cycle.
- Simultaneous events:
  - `mem_ready`=1 on the timeout edge: the capture wins and `fetch_err` stays 0.
  - `reset` together with `fetch_req`: reset wins.

## Test plan
- Reset and zero-wait fetch:
  - Stimulus: `reset` for 2 cycles. Then `pc`=0x00400000, `fetch_req`=1 for one cycle. Memory returns 0x2008FFFC (addi $t0,$zero,-4) with `mem_ready` the next cycle.
  - Required: `mem_addr`=0x00400000 and `mem_rd`=1 for exactly 1 cycle. After that, `ir`=0x2008FFFC, `opcode`=0x08, `rs`=0, `rt`=8, `imm`=0xFFFC, and a single `ir_valid` pulse.
- Wait states:
  - Stimulus: `mem_ready` delayed 5 cycles, `rdata`=0x012A4020 (add).
  - Required: `busy`=1 for 5 cycles, then `rd`=8, `funct`=0x20, `shamt`=0. `pc` toggled during WAIT does not change `mem_addr`.
- Timeout, TIMEOUT=4:
  - Stimulus: `mem_ready` never asserted.
  - Required: `fetch_err`=1 after edge E0+4; `busy` and `mem_rd` drop; `ir` keeps its previous value. A new `fetch_req` clears `fetch_err` on its accept edge.
- Ignored inputs:
  - Stimulus: `fetch_req` pulsed during WAIT, and `mem_ready` pulsed in IDLE.
  - Required: exactly one memory read is issued; `ir` is unchanged by the IDLE `mem_ready`.
- Back-to-back and reset mid-fetch:
  - Stimulus: `fetch_req` asserted in the `ir_valid` cycle; then `reset` in the second WAIT cycle of the following fetch.
  - Required: the second read starts immediately after the first capture. The reset returns all outputs to 0 the next cycle, and no capture happens when `mem_ready` arrives late.
- Priority on the timeout edge, TIMEOUT=3:
  - Stimulus: `mem_ready`=1 on the 3rd WAIT edge.
  - Required: capture occurs, `fetch_err`=0.
